// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush/bubble control and a late-data hold buffer; latency 1 cycle.
// Backpressure comes only from the stall vector: hold when this and the next stage stall, bubble when only this one does.
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter int                LATE_W     = 32,
    parameter int                STALL_W    = 4,
    parameter int                STAGE      = 1,
    parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(64'h3000_3000),
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter logic [LATE_W-1:0] NOP_VAL    = '0,
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [LATE_W-1:0]  late_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [LATE_W-1:0]  out_late,
    output logic               hold_vld,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic              s_me;
    logic              s_nx;
    logic              nop_q;
    logic [LATE_W-1:0] hold_buf;
    logic              unused_stall;

    assign s_me = stall[STAGE];

    // The last stage has no downstream stall, so its stalls always become bubbles.
    generate
        if (STAGE + 1 < STALL_W) begin : g_nx
            assign s_nx = stall[STAGE+1];
        end else begin : g_last
            assign s_nx = 1'b0;
        end
    endgenerate

    assign unused_stall = ^stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= RST_VAL;
            nop_q      <= 1'b1;
            hold_vld   <= 1'b0;
            hold_buf   <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
            nop_q     <= 1'b1;
            hold_vld  <= 1'b0;
        end else if (s_me && !s_nx) begin
            out_valid <= 1'b0;
            out_data  <= BUBBLE_VAL;
            nop_q     <= 1'b1;
            hold_vld  <= 1'b0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else if (!s_me) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            nop_q     <= !in_valid;
            hold_vld  <= 1'b0;
        end else if (!hold_vld && !nop_q) begin
            // Memory output is only valid the cycle after the edge; latch it once per hold.
            hold_buf <= late_data;
            hold_vld <= 1'b1;
        end
    end

    assign out_late = nop_q ? NOP_VAL : (hold_vld ? hold_buf : late_data);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: a middle stage (STAGE=1) and a last stage with a 2-bit counter.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [31:0] late_data;

    logic        ov0, hv0, ov1, hv1;
    logic [63:0] od0, od1;
    logic [31:0] ol0, ol1;
    logic [15:0] bc0;
    logic [1:0]  bc1;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .late_data(late_data),
        .out_valid(ov0), .out_data(od0), .out_late(ol0), .hold_vld(hv0), .bubble_cnt(bc0)
    );

    pipe_stage_reg #(.STAGE(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .late_data(late_data),
        .out_valid(ov1), .out_data(od1), .out_late(ol1), .hold_vld(hv1), .bubble_cnt(bc1)
    );

    // Reference view of one stage: what slot it holds and whether a late word is parked.
    typedef struct {
        bit          valid;
        logic [63:0] data;
        bit          nop;
        bit          held;
        logic [31:0] word;
        int          cnt;
    } slot_t;

    typedef struct {
        logic        ov0, hv0, ov1, hv1;
        logic [63:0] od0, od1;
        logic [31:0] ol0, ol1;
        logic [15:0] bc0;
        logic [1:0]  bc1;
    } exp_t;

    exp_t  sb[$];
    slot_t m0, m1;

    function automatic slot_t slot_reset();
        slot_t s;
        s.valid = 1'b0;
        s.data  = 64'h3000_3000;
        s.nop   = 1'b1;
        s.held  = 1'b0;
        s.word  = '0;
        s.cnt   = 0;
        return s;
    endfunction

    function automatic logic [31:0] late_of(slot_t s, logic [31:0] lt);
        if (s.nop)  return 32'h0;
        if (s.held) return s.word;
        return lt;
    endfunction

    function automatic slot_t model_edge(slot_t s, int stage, int cmax, logic [3:0] st,
                                         logic fl, logic iv, logic [63:0] id, logic [31:0] lt);
        slot_t n = s;
        bit me = st[stage];
        bit nx = 1'b0;
        if (stage < 3) nx = st[stage+1];
        if (fl) begin
            n = slot_reset();
            n.word = s.word;
            n.cnt  = s.cnt;
        end else if (me && !nx) begin
            n.valid = 1'b0;
            n.data  = 64'h0;
            n.nop   = 1'b1;
            n.held  = 1'b0;
            if (s.cnt < cmax) n.cnt = s.cnt + 1;
        end else if (!me) begin
            n.valid = iv;
            n.data  = id;
            n.nop   = !iv;
            n.held  = 1'b0;
        end else if (!s.held && !s.nop) begin
            n.held = 1'b1;
            n.word = lt;
        end
        return n;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Inputs are driven just after an edge; the expectation covers the cycle until the next edge.
    task automatic step(logic [3:0] st, logic fl, logic iv, logic [63:0] id, logic [31:0] lt);
        exp_t e;
        stall = st; flush = fl; in_valid = iv; in_data = id; late_data = lt;
        e.ov0 = m0.valid; e.od0 = m0.data; e.ol0 = late_of(m0, lt); e.hv0 = m0.held;
        e.bc0 = 16'(m0.cnt);
        e.ov1 = m1.valid; e.od1 = m1.data; e.ol1 = late_of(m1, lt); e.hv1 = m1.held;
        e.bc1 = 2'(m1.cnt);
        sb.push_back(e);
        m0 = model_edge(m0, 1, 65535, st, fl, iv, id, lt);
        m1 = model_edge(m1, 3, 3, st, fl, iv, id, lt);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_valid"},    64'(ov0), 64'h0);
        check({tag, "_data"},     od0, 64'h3000_3000);
        check({tag, "_late"},     64'(ol0), 64'h0);
        check({tag, "_hold"},     64'(hv0), 64'h0);
        check({tag, "_cnt"},      64'(bc0), 64'h0);
        check({tag, "_sat_cnt"},  64'(bc1), 64'h0);
        check({tag, "_sat_data"}, od1, 64'h3000_3000);
    endtask

    // Reset lands between edges; outputs must clear before any clock arrives.
    task automatic reset_mid();
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        m0 = slot_reset();
        m1 = slot_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rand_steps(int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(st, ($urandom_range(0, 15) == 0), 1'($urandom), {$urandom, $urandom}, $urandom);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_valid",     64'(ov0), 64'(e.ov0));
                check("out_data",      od0, e.od0);
                check("out_late",      64'(ol0), 64'(e.ol0));
                check("hold_vld",      64'(hv0), 64'(e.hv0));
                check("bubble_cnt",    64'(bc0), 64'(e.bc0));
                check("sat_out_valid", 64'(ov1), 64'(e.ov1));
                check("sat_out_data",  od1, e.od1);
                check("sat_out_late",  64'(ol1), 64'(e.ol1));
                check("sat_hold_vld",  64'(hv1), 64'(e.hv1));
                check("sat_bubble_cnt",64'(bc1), 64'(e.bc1));
            end
        end
    end

    initial begin : driver
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; late_data = '0;
        m0 = slot_reset();
        m1 = slot_reset();
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Advance a valid slot, then late data follows it.
        step(4'b0000, 1'b0, 1'b1, 64'h3004_3008, 32'h1111_1111);
        step(4'b0000, 1'b0, 1'b1, 64'h3008_300C, 32'h2222_2222);
        // Multi-cycle hold captures only the first late word.
        step(4'b0110, 1'b0, 1'b1, 64'h300C_3010, 32'hDEAD_BEEF);
        step(4'b0110, 1'b0, 1'b1, 64'h300C_3010, 32'hCAFE_0001);
        step(4'b0110, 1'b0, 1'b1, 64'h300C_3010, 32'h1234_5678);
        step(4'b0000, 1'b0, 1'b1, 64'h300C_3010, 32'h5555_AAAA);
        step(4'b0000, 1'b0, 1'b1, 64'h3010_3014, 32'h6666_7777);
        // Two bubbles on the middle stage.
        step(4'b0010, 1'b0, 1'b1, 64'h3014_3018, 32'h0BAD_F00D);
        step(4'b0010, 1'b0, 1'b1, 64'h3014_3018, 32'h0BAD_F00E);
        step(4'b0000, 1'b0, 1'b1, 64'h3014_3018, 32'h1357_9BDF);
        // Flush while a hold is in progress.
        step(4'b0000, 1'b0, 1'b1, 64'h3018_301C, 32'hAAAA_0000);
        step(4'b0110, 1'b0, 1'b1, 64'h301C_3020, 32'hBBBB_0000);
        step(4'b0110, 1'b1, 1'b1, 64'h301C_3020, 32'hCCCC_0000);
        step(4'b0000, 1'b0, 1'b0, 64'h301C_3020, 32'hDDDD_0000);
        // Last stage: every stall is a bubble; 2-bit counter must stick at 3.
        for (int i = 0; i < 5; i++) step(4'b1000, 1'b0, 1'b1, 64'(i), 32'(i));
        step(4'b0000, 1'b1, 1'b0, 64'h0, 32'h0);
        step(4'b0000, 1'b0, 1'b1, 64'h4000_0000, 32'hFEED_0000);

        reset_mid();
        rand_steps(300);
        reset_mid();
        rand_steps(300);

        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
